// File: rtl/painterengine_gpu_raster_scanner_pkg.sv
// painterengine_gpu_raster_scanner_pkg: shared state encoding and {y,x} point packing helpers
package painterengine_gpu_raster_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BBOX = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } scan_state_t;

    localparam int X_LSB = 0;
    localparam int Y_LSB = 16;
    localparam int COORD_W = 16;

    function automatic logic [31:0] pack_point(input logic [COORD_W-1:0] y, input logic [COORD_W-1:0] x);
        logic [31:0] p;
        p = '0;
        p[Y_LSB +: COORD_W] = y;
        p[X_LSB +: COORD_W] = x;
        return p;
    endfunction

    function automatic logic [COORD_W-1:0] point_x(input logic [31:0] p);
        return p[X_LSB +: COORD_W];
    endfunction

    function automatic logic [COORD_W-1:0] point_y(input logic [31:0] p);
        return p[Y_LSB +: COORD_W];
    endfunction

endpackage

// File: rtl/painterengine_gpu_raster_scanner_bbox_clip.sv
// painterengine_gpu_bbox_clip: signed min/max of three vertices clipped to the screen rectangle
module painterengine_gpu_bbox_clip
    import painterengine_gpu_raster_scanner_pkg::*;
#(
    parameter int SCREEN_WIDTH = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic [31:0]        point1,
    input  logic [31:0]        point2,
    input  logic [31:0]        point3,
    output logic [COORD_W-1:0] xmin,
    output logic [COORD_W-1:0] xmax,
    output logic [COORD_W-1:0] ymin,
    output logic [COORD_W-1:0] ymax,
    output logic               empty
);
    localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_WIDTH - 1);
    localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_HEIGHT - 1);
    localparam logic signed [COORD_W-1:0] ZERO = '0;
    logic signed [COORD_W-1:0] x1, x2, x3, y1, y2, y3;
    logic signed [COORD_W-1:0] lo_x, hi_x, lo_y, hi_y, cx0, cx1, cy0, cy1;
    always_comb begin
        x1 = $signed(point_x(point1));
        x2 = $signed(point_x(point2));
        x3 = $signed(point_x(point3));
        y1 = $signed(point_y(point1));
        y2 = $signed(point_y(point2));
        y3 = $signed(point_y(point3));
        lo_x = x1 < x2 ? x1 : x2;
        lo_x = x3 < lo_x ? x3 : lo_x;
        hi_x = x1 > x2 ? x1 : x2;
        hi_x = x3 > hi_x ? x3 : hi_x;
        lo_y = y1 < y2 ? y1 : y2;
        lo_y = y3 < lo_y ? y3 : lo_y;
        hi_y = y1 > y2 ? y1 : y2;
        hi_y = y3 > hi_y ? y3 : hi_y;
        cx0 = lo_x < ZERO ? ZERO : lo_x;
        cx1 = hi_x > X_LIM ? X_LIM : hi_x;
        cy0 = lo_y < ZERO ? ZERO : lo_y;
        cy1 = hi_y > Y_LIM ? Y_LIM : hi_y;
        // a box entirely off one side clips to lo > hi, which marks it empty
        empty = (cx0 > cx1) || (cy0 > cy1);
        xmin = cx0;
        xmax = cx1;
        ymin = cy0;
        ymax = cy1;
    end
endmodule

// File: rtl/painterengine_gpu_raster_scanner.sv
// painterengine_gpu_raster_scanner: accepts a triangle, clips its bounding box and
// issues every pixel of that box in row-major order, one test point per cycle.
module painterengine_gpu_raster_scanner
    import painterengine_gpu_raster_scanner_pkg::*;
#(
    parameter int SCREEN_WIDTH = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_reset,
    input  logic        i_wire_cmd_valid,
    output logic        o_wire_cmd_ready,
    input  logic [31:0] i_wire_point1,
    input  logic [31:0] i_wire_point2,
    input  logic [31:0] i_wire_point3,
    input  logic [31:0] i_wire_yes_color,
    input  logic [31:0] i_wire_no_color,
    input  logic        i_wire_out_ready,
    output logic        o_wire_valid,
    output logic [31:0] o_wire_test_point,
    output logic [31:0] o_wire_point1,
    output logic [31:0] o_wire_point2,
    output logic [31:0] o_wire_point3,
    output logic [31:0] o_wire_yes_color,
    output logic [31:0] o_wire_no_color,
    output logic        o_wire_done,
    output logic [31:0] o_wire_pixel_count
);
    scan_state_t state, state_next;
    logic [COORD_W-1:0] box_xmin, box_xmax, box_ymin, box_ymax;
    logic [COORD_W-1:0] xmin_r, xmax_r, ymin_r, ymax_r, cur_x, cur_y;
    logic box_empty, accept, fire, last;

    painterengine_gpu_bbox_clip #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_bbox_clip (
        .point1(o_wire_point1),
        .point2(o_wire_point2),
        .point3(o_wire_point3),
        .xmin  (box_xmin),
        .xmax  (box_xmax),
        .ymin  (box_ymin),
        .ymax  (box_ymax),
        .empty (box_empty)
    );

    always_comb begin
        o_wire_cmd_ready = state == IDLE;
        o_wire_valid = state == SCAN;
        o_wire_done = state == DONE;
        o_wire_test_point = pack_point(cur_y, cur_x);
        accept = i_wire_cmd_valid && state == IDLE;
        fire = state == SCAN && i_wire_out_ready;
        last = cur_x == xmax_r && cur_y == ymax_r;
        state_next = state == IDLE ? (accept ? BBOX : IDLE)
                   : state == BBOX ? (box_empty ? DONE : SCAN)
                   : state == SCAN ? (fire && last ? DONE : SCAN)
                   : IDLE;
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            o_wire_point1 <= '0;
            o_wire_point2 <= '0;
            o_wire_point3 <= '0;
            o_wire_yes_color <= '0;
            o_wire_no_color <= '0;
            o_wire_pixel_count <= '0;
            xmin_r <= '0;
            xmax_r <= '0;
            ymin_r <= '0;
            ymax_r <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else begin
            if (accept) begin
                o_wire_point1 <= i_wire_point1;
                o_wire_point2 <= i_wire_point2;
                o_wire_point3 <= i_wire_point3;
                o_wire_yes_color <= i_wire_yes_color;
                o_wire_no_color <= i_wire_no_color;
                o_wire_pixel_count <= '0;
            end
            if (state == BBOX) begin
                xmin_r <= box_xmin;
                xmax_r <= box_xmax;
                ymin_r <= box_ymin;
                ymax_r <= box_ymax;
                cur_x <= box_xmin;
                cur_y <= box_ymin;
            end
            // the last pixel leaves cur in place so test_point keeps showing it
            if (fire) begin
                o_wire_pixel_count <= o_wire_pixel_count + 32'd1;
                if (cur_x != xmax_r) cur_x <= cur_x + 1'b1;
                else if (cur_y != ymax_r) begin
                    cur_x <= xmin_r;
                    cur_y <= cur_y + 1'b1;
                end
            end
        end
    end
endmodule
